// File: rtl/display_controller.sv
// Display line/frame pacing controller with a double-flopped, stretched distributed reset.
// Optional inter-line blanking is compiled in by defining DISPLAY_CONTROLLER_BLANKING_EN.
module display_controller #(
  parameter int WORDS_PER_LINE  = 16,
  parameter int LINES_PER_FRAME = 1280,
  parameter int RESET_STRETCH   = 16,
  parameter int BLANK_CYCLES    = 4
) (
  input  logic       fpga_clk,
  input  logic       reset_all_n,
  output logic       reset_all,
  input  logic [4:0] num_words_in_buffer,
  output logic       line_of_data_available,
  output logic       next_frame_rdy_o
);

`ifdef DISPLAY_CONTROLLER_BLANKING_EN
  typedef enum logic [1:0] {
    WAIT_LINE  = 2'd0,
    SEND_LINE  = 2'd1,
    FRAME_DONE = 2'd2,
    BLANK      = 2'd3
  } state_e;
  localparam logic [3:0] LAST_BLANK = 4'(BLANK_CYCLES - 1);
`else
  typedef enum logic [1:0] {
    WAIT_LINE  = 2'd0,
    SEND_LINE  = 2'd1,
    FRAME_DONE = 2'd2
  } state_e;
`endif

  localparam logic [4:0]  WPL       = 5'(WORDS_PER_LINE);
  localparam logic [4:0]  LAST_WORD = 5'(WORDS_PER_LINE - 1);
  localparam logic [10:0] LPF       = 11'(LINES_PER_FRAME);

  // Two edges are spent in the synchronizer, so the counter covers the remaining
  // RESET_STRETCH-2; a stretch of 2 is exactly the synchronizer depth.
  localparam bit         SHORT_STRETCH = (RESET_STRETCH < 3);
  localparam logic [7:0] STRETCH_LAST  = SHORT_STRETCH ? 8'd0 : 8'(RESET_STRETCH - 3);

  logic [1:0]  sync_q, sync_d;
  logic [7:0]  stretch_q, stretch_d;
  logic        reset_all_q, reset_all_d;

  state_e      state_q, state_d;
  logic [4:0]  word_q, word_d;
  logic [10:0] line_q, line_d;
  logic        lda_q, lda_d;
  logic        nfr_q, nfr_d;
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
  logic [3:0]  blank_q, blank_d;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sync_d      = {sync_q[0], 1'b1};
    stretch_d   = stretch_q;
    if (sync_q[1] && !reset_all_q) stretch_d = stretch_q + 8'd1;
    reset_all_d = reset_all_q |
                  (SHORT_STRETCH ? sync_q[0] : (sync_q[1] && (stretch_q == STRETCH_LAST)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge fpga_clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      sync_q      <= 2'b00;
      stretch_q   <= 8'd0;
      reset_all_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      stretch_q   <= stretch_d;
      reset_all_q <= reset_all_d;
    end
  end

  // State register
  always_ff @(posedge fpga_clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      state_q <= WAIT_LINE;
      word_q  <= 5'd0;
      line_q  <= 11'd0;
      lda_q   <= 1'b0;
      nfr_q   <= 1'b0;
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
      blank_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      line_q  <= line_d;
      lda_q   <= lda_d;
      nfr_q   <= nfr_d;
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
      blank_q <= blank_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    line_d  = line_q;
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
    blank_d = blank_q;
`endif
    case (state_q)
      WAIT_LINE: begin
        if (num_words_in_buffer >= WPL) begin
          state_d = SEND_LINE;
          word_d  = 5'd0;
        end
      end
      SEND_LINE: begin
        if (word_q == LAST_WORD) begin
          if (line_q + 11'd1 == LPF) begin
            state_d = FRAME_DONE;
            line_d  = 11'd0;
          end else begin
            line_d  = line_q + 11'd1;
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
            state_d = BLANK;
            blank_d = 4'd0;
`else
            state_d = WAIT_LINE;
`endif
          end
        end else begin
          word_d = word_q + 5'd1;
        end
      end
      FRAME_DONE: begin
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
        state_d = BLANK;
        blank_d = 4'd0;
`else
        state_d = WAIT_LINE;
`endif
      end
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
      BLANK: begin
        if (blank_q == LAST_BLANK) state_d = WAIT_LINE;
        else                       blank_d = blank_q + 4'd1;
      end
`endif
      default: state_d = WAIT_LINE;
    endcase

    // Until the distributed reset is released the controller idles with cleared counters.
    if (!reset_all_q) begin
      state_d = WAIT_LINE;
      word_d  = 5'd0;
      line_d  = 11'd0;
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
      blank_d = 4'd0;
`endif
    end
  end

  // Output logic: decoded from the next state so the flops line up with the state they describe.
  always_comb begin
    lda_d = (state_d == SEND_LINE);
    nfr_d = (state_d == FRAME_DONE);
  end

  assign reset_all              = reset_all_q;
  assign line_of_data_available = lda_q;
  assign next_frame_rdy_o       = nfr_q;

endmodule

// File: tb/tb_display_controller.sv
// Randomized scoreboard bench for display_controller: a timeline-based reference model
// queues the expected outputs per cycle and a negedge monitor compares them.
`timescale 1ns/1ps
module tb_display_controller;

  localparam int WORDS  = 16;
  localparam int LINES  = 4;
  localparam int STRETCH = 16;
  localparam int BLANKS = 4;

  logic       fpga_clk = 1'b0;
  logic       reset_all_n = 1'b0;
  logic [4:0] num_words_in_buffer = 5'd0;
  logic       reset_all;
  logic       line_of_data_available;
  logic       next_frame_rdy_o;

  int n_tests = 0;
  int n_fail  = 0;

  display_controller #(
    .WORDS_PER_LINE (WORDS),
    .LINES_PER_FRAME(LINES),
    .RESET_STRETCH  (STRETCH),
    .BLANK_CYCLES   (BLANKS)
  ) dut (
    .fpga_clk              (fpga_clk),
    .reset_all_n           (reset_all_n),
    .reset_all             (reset_all),
    .num_words_in_buffer   (num_words_in_buffer),
    .line_of_data_available(line_of_data_available),
    .next_frame_rdy_o      (next_frame_rdy_o)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {reset_all,lda,nfr}=%b, expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Controller behaviour is a timeline: a line start schedules its whole burst, the frame pulse
  // (every LINES-th line) and any blanking; once the schedule drains there is one idle cycle.
  logic [2:0]  exp_q[$];     // {reset_all, lda, nfr} per cycle
  logic [1:0]  m_sched[$];   // {lda, nfr} still to be emitted
  int unsigned m_rel   = 0;  // edges since reset_all_n was released
  bit          m_rst   = 1'b0;
  int unsigned m_lines = 0;
  bit          m_idle  = 1'b1;

  always @(posedge fpga_clk) begin
    logic [1:0] o;
    bit en;
    o  = 2'b00;
    en = m_rst;
    if (!reset_all_n) begin
      m_rel = 0; m_rst = 1'b0; m_lines = 0; m_idle = 1'b1;
      m_sched.delete();
    end else begin
      if (m_rel < 1000) m_rel++;
      m_rst = (m_rel >= STRETCH);
      if (!en) begin
        m_lines = 0; m_idle = 1'b1;
        m_sched.delete();
      end else if (m_sched.size() > 0) begin
        o = m_sched.pop_front();
        m_idle = 1'b0;
      end else if (m_idle && (int'(num_words_in_buffer) >= WORDS)) begin
        for (int i = 0; i < WORDS; i++) m_sched.push_back(2'b10);
        m_lines++;
        if (m_lines == LINES) begin
          m_sched.push_back(2'b01);
          m_lines = 0;
        end
`ifdef DISPLAY_CONTROLLER_BLANKING_EN
        for (int i = 0; i < BLANKS; i++) m_sched.push_back(2'b00);
`endif
        o = m_sched.pop_front();
        m_idle = 1'b0;
      end else begin
        m_idle = 1'b1;
      end
    end
    exp_q.push_back({m_rst, o});
  end

  // An asynchronous reset forces the current cycle's outputs low before the monitor samples.
  always @(negedge reset_all_n) begin
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      exp_q.push_back(3'b000);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge fpga_clk) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", {reset_all, line_of_data_available, next_frame_rdy_o}, e);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge fpga_clk);
      #2;
    end
  endtask

  task automatic pulse_reset(input int low_cycles);
    reset_all_n = 1'b0;
    tick(low_cycles);
    reset_all_n = 1'b1;
  endtask

  initial begin
    bit found;

    // Power-on reset with a full buffer: nothing may start before the stretch completes.
    num_words_in_buffer = 5'd31;
    tick(3);
    reset_all_n = 1'b1;
    tick(30);

    // Short reset pulse with an empty buffer.
    num_words_in_buffer = 5'd0;
    pulse_reset(3);
    tick(25);

    // One word short never starts a line; the threshold does.
    num_words_in_buffer = 5'd15;
    tick(50);
    num_words_in_buffer = 5'd16;
    tick(40);

    // Continuous full buffer: several complete frames back to back.
    num_words_in_buffer = 5'd31;
    tick(200);

    // Abort the third line at its eighth word, then run a clean frame.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1);
      if (m_lines == 3 && m_sched.size() == WORDS - 8) found = 1'b1;
    end
    check("mid_line_reached", {2'b00, found}, 3'b001);
    pulse_reset(3);
    tick(130);

    // Buffer drains mid-line: the burst completes and no new line starts until refilled.
    num_words_in_buffer = 5'd0;
    tick(10);
    num_words_in_buffer = 5'd16;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (m_sched.size() > 0) found = 1'b1;
    end
    check("line_started", {2'b00, found}, 3'b001);
    tick(3);
    num_words_in_buffer = 5'd0;
    tick(40);
    num_words_in_buffer = 5'd20;
    tick(30);

    // Random buffer levels with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) num_words_in_buffer = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 499) == 0) pulse_reset($urandom_range(1, 3));
      tick(1);
    end

    @(negedge fpga_clk);
    #1;
    check("scoreboard_drained", {2'b00, exp_q.size() == 0}, 3'b001);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 16 (legal 1..31); words consumed per line.
REQ-002 SHALL have parameter LINES_PER_FRAME, default 1280 (legal 1..2047); lines per frame.
REQ-003 SHALL have parameter RESET_STRETCH, default 16 (legal 2..255); clock cycles reset_all is held after external reset release.
REQ-004 SHALL have parameter BLANK_CYCLES, default 4 (legal 1..15); idle cycles between lines when blanking is compiled in.
REQ-005 fpga_clk  input  1  sole clock; all state on rising edge.
REQ-006 reset_all_n  input  1  external reset; one clock, reset asynchronous and active-low.
REQ-007 reset_all  output  1  distributed system reset, active-low, registered.
REQ-008 num_words_in_buffer  input  5  current line-buffer fill level, 0..31, synchronous to fpga_clk.
REQ-009 line_of_data_available  output  1  high while the downstream reader takes one word per cycle of the current line.
REQ-010 next_frame_rdy_o  output  1  one-cycle pulse marking completion of a full frame.

Function
REQ-011 reset_all SHALL go low asynchronously with reset_all_n, and go high synchronously exactly RESET_STRETCH rising edges after reset_all_n rises; the input is double-flopped before the stretch counter.
REQ-012 The controller FSM SHALL be held in WAIT_LINE, with its counters cleared, whenever reset_all is low.
REQ-013 FSM states SHALL be WAIT_LINE, SEND_LINE, BLANK (blanking build only) and FRAME_DONE, binary-encoded; unreachable encodings SHALL return to WAIT_LINE.
REQ-014 In WAIT_LINE, if num_words_in_buffer >= WORDS_PER_LINE at a rising edge, the FSM SHALL enter SEND_LINE, and line_of_data_available SHALL be high from that edge; a value of WORDS_PER_LINE-1 SHALL NOT start a line.
REQ-015 line_of_data_available SHALL stay high for exactly WORDS_PER_LINE consecutive cycles; num_words_in_buffer is ignored during SEND_LINE.
REQ-016 At the end of SEND_LINE, the 11-bit line counter SHALL increment.
REQ-017 If the completed line is line LINES_PER_FRAME, the FSM SHALL enter FRAME_DONE, the line counter SHALL clear, and next_frame_rdy_o SHALL be high for exactly that one cycle before the FSM returns to WAIT_LINE.
REQ-018 Otherwise the FSM SHALL return to WAIT_LINE (or enter BLANK).
REQ-019 line_of_data_available SHALL be low for at least one cycle between consecutive lines, since WAIT_LINE always occupies at least one cycle.
REQ-020 next_frame_rdy_o and line_of_data_available SHALL never be high in the same cycle.
REQ-021 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-022 While reset_all_n is low: reset_all=0, line_of_data_available=0, next_frame_rdy_o=0, line counter=0, state=WAIT_LINE.
REQ-023 Reset asserted mid-line SHALL abort the line immediately; the partial line SHALL NOT be counted.
REQ-024 The first line SHALL be able to start no earlier than the cycle after reset_all goes high.

Configuration
REQ-025 Macro DISPLAY_CONTROLLER_BLANKING_EN: when defined, every line end (after FRAME_DONE when applicable) SHALL pass through BLANK for exactly BLANK_CYCLES cycles, with both data outputs low, before WAIT_LINE; when undefined, BLANK SHALL not exist and the minimum inter-line gap is one cycle.

Verification (LINES_PER_FRAME=4, WORDS_PER_LINE=16, RESET_STRETCH=16 unless stated)
REQ-026 Pulse reset_all_n low 3 cycles then high -> reset_all low immediately, high exactly 16 edges after release; data outputs 0 throughout.
REQ-027 Hold num_words_in_buffer=15 for 50 cycles -> line_of_data_available stays 0; step to 16 -> high on the next edge for exactly 16 cycles.
REQ-028 Hold num_words_in_buffer=31 continuously -> 4 bursts of 16 with 1-cycle gaps (1+BLANK_CYCLES with macro), then one next_frame_rdy_o pulse after the 4th burst; counter then restarts.
REQ-029 Assert reset_all_n mid-burst (word 8 of line 3) -> outputs 0 asynchronously; after recovery, 4 full lines are needed before next_frame_rdy_o.
REQ-030 Drop num_words_in_buffer to 0 during SEND_LINE -> burst still lasts 16 cycles; no new line starts until the level is >=16 again.
